hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage MIPS core. Drives the write enables and

---
 rtl/mips_pkg.sv | 12 +
 rtl/hazard_ctrl_sat_counter.sv | 18 +
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stall, taken-branch flush and data-memory wait
// with timeout for the 5-stage MIPS core.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rt,
  input  logic             MEM_br_taken,
  input  logic             MEM_mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_write,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_bubble,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  logic              run_eval;
  logic              freeze;
  logic              br_event;

  assign load_use  = EX_MemRead && (EX_rt != REG_ZERO) &&
                     ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
  assign mem_stall = MEM_mem_req && !mem_ready;

  // A completing MEM_WAIT cycle is resolved exactly like a RUN cycle.
  always_comb begin
    run_eval = 1'b0;
    freeze   = 1'b0;
    br_event = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN:      run_eval = 1'b1;
        ST_MEM_WAIT: if (mem_ready) run_eval = 1'b1; else freeze = 1'b1;
        default:     freeze = 1'b1;
      endcase
    end
    if (run_eval) begin
      if (mem_stall)
        freeze = 1'b1;
      else if (MEM_br_taken)
        br_event = 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_write   = 1'b1;
    ID_EX_bubble  = 1'b0;
    EX_MEM_write  = 1'b1;
    EX_MEM_flush  = 1'b0;
    MEM_WB_bubble = 1'b0;
    if (freeze) begin
      pc_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      EX_MEM_write  = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (br_event) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
      EX_MEM_flush = 1'b1;
    end else if (run_eval && load_use) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  // wait_cnt holds the number of MEM_WAIT cycles already spent in this access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) begin
            state       <= ST_ERROR;
            err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_RUN;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_event),
    .count (flush_cnt)
  );

endmodule
